// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control/status bundle between front panel, datapath and phase sequencer
interface phase_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               start;
  logic               stop;
  logic               step_mode;
  logic               step_req;
  logic               mem_wait;
  logic [15:0]        instruction;
  logic [2:0]         phase;
  logic               running;
  logic               halted;
  logic               retire;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output start, stop, step_mode, step_req, mem_wait, instruction,
    input  phase, running, halted, retire, instr_count
  );

  modport slave (
    input  start, stop, step_mode, step_req, mem_wait, instruction,
    output phase, running, halted, retire, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - instruction phase sequencer with run/stop/step, HLT and memory-wait stretch
module phase_sequencer #(
  parameter int LAST_PHASE = 5,
  parameter int HOLD_PHASE = 4,
  parameter int COUNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  phase_sequencer_if.slave  bus
);

  localparam logic [2:0] PH_LAST = 3'(LAST_PHASE);
  localparam logic [2:0] PH_HOLD = 3'(HOLD_PHASE);
  localparam logic [2:0] PH_DEC  = 3'd2;
  localparam logic [2:0] PH_ONE  = 3'd1;
  localparam logic [2:0] PH_IDLE = 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP_WAIT,
    S_HALT
  } state_t;

  state_t             state;
  logic [2:0]         phase_r;
  logic               running_r;
  logic               halted_r;
  logic               retire_r;
  logic [COUNT_W-1:0] count_r;
  logic               stop_pending;

  logic start_q, stop_q, step_q;
  logic start_e, stop_e, step_e;
  logic is_hlt;

  assign start_e = bus.start    & ~start_q;
  assign stop_e  = bus.stop     & ~stop_q;
  assign step_e  = bus.step_req & ~step_q;

  // HLT opcode: top two bits set and function nibble [7:4] all ones
  assign is_hlt = ((bus.instruction & 16'hC0F0) == 16'hC0F0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase_r      <= PH_IDLE;
      running_r    <= 1'b0;
      halted_r     <= 1'b0;
      retire_r     <= 1'b0;
      count_r      <= '0;
      stop_pending <= 1'b0;
      // a level held through reset must not look like a fresh edge afterwards
      start_q      <= bus.start;
      stop_q       <= bus.stop;
      step_q       <= bus.step_req;
    end else begin
      start_q  <= bus.start;
      stop_q   <= bus.stop;
      step_q   <= bus.step_req;
      retire_r <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_e) begin
            state     <= S_RUN;
            phase_r   <= PH_ONE;
            running_r <= 1'b1;
          end
        end

        S_RUN: begin
          if (stop_e) begin
            stop_pending <= 1'b1;
          end

          if (phase_r == PH_HOLD && bus.mem_wait) begin
            phase_r <= phase_r;
          end else if (phase_r == PH_DEC && is_hlt) begin
            state        <= S_HALT;
            phase_r      <= PH_IDLE;
            running_r    <= 1'b0;
            halted_r     <= 1'b1;
            stop_pending <= 1'b0;
          end else if (phase_r == PH_LAST) begin
            retire_r <= 1'b1;
            count_r  <= count_r + COUNT_W'(1);
            // a stop arriving in this very cycle still ends the run here
            if (stop_pending || stop_e) begin
              state        <= S_IDLE;
              phase_r      <= PH_IDLE;
              running_r    <= 1'b0;
              stop_pending <= 1'b0;
            end else if (bus.step_mode) begin
              state        <= S_STEP_WAIT;
              phase_r      <= PH_IDLE;
              running_r    <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              phase_r <= PH_ONE;
            end
          end else begin
            phase_r <= phase_r + 3'd1;
          end
        end

        S_STEP_WAIT: begin
          if (step_e || (start_e && !bus.step_mode)) begin
            state     <= S_RUN;
            phase_r   <= PH_ONE;
            running_r <= 1'b1;
          end else if (stop_e) begin
            state <= S_IDLE;
          end
        end

        S_HALT: begin
          phase_r   <= PH_IDLE;
          running_r <= 1'b0;
          halted_r  <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          phase_r   <= PH_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase       = phase_r;
  assign bus.running     = running_r;
  assign bus.halted      = halted_r;
  assign bus.retire      = retire_r;
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - bench for phase_sequencer: vector table, corner sequences, random vs model
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_sequencer_if #(.COUNT_W(16)) bus ();
  phase_sequencer_if #(.COUNT_W(3))  bus3 ();

  phase_sequencer #(.LAST_PHASE(5), .HOLD_PHASE(4), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  phase_sequencer #(.LAST_PHASE(5), .HOLD_PHASE(4), .COUNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          start, stop, step_mode, step_req, mem_wait;
    logic [15:0] instr;
    logic [2:0]  e_phase;
    bit          e_halted, e_retire;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl[$];

  // reference model state: phase as a plain number plus a few flags
  int          m_phase;
  bit          m_halt, m_waitstep, m_stopreq, m_retire;
  logic [15:0] m_count;
  bit          p_start, p_stop, p_step;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    return {10'b0, bus.phase, bus.running, bus.halted, bus.retire, bus.instr_count};
  endfunction

  function automatic logic [31:0] exp_pack(input logic [2:0] ph, input bit h, input bit ret,
                                           input logic [15:0] cnt);
    return {10'b0, ph, (ph != 3'd0), h, ret, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int ph, input bit h, input bit ret,
                            input int cnt);
    check(name, dut_pack(), exp_pack(3'(ph), h, ret, 16'(cnt)));
  endtask

  task automatic drive(input bit st, input bit sp, input bit sm, input bit sr, input bit mw,
                       input logic [15:0] ins);
    bus.start = st; bus.stop = sp; bus.step_mode = sm; bus.step_req = sr;
    bus.mem_wait = mw; bus.instruction = ins;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 16'h0000);
    bus3.start = 0; bus3.stop = 0; bus3.step_mode = 0; bus3.step_req = 0;
    bus3.mem_wait = 0; bus3.instruction = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    expect_out("reset_state", 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit sp, input bit sm, input bit sr,
                            input bit mw, input logic [15:0] ins);
    bit se, pe, re, hlt;
    se = st && !p_start;
    pe = sp && !p_stop;
    re = sr && !p_step;
    hlt = (ins[15:14] == 2'b11) && (ins[7:4] == 4'hF);
    p_start = st; p_stop = sp; p_step = sr;
    m_retire = 0;
    if (r) begin
      m_phase = 0; m_halt = 0; m_waitstep = 0; m_stopreq = 0; m_count = 0;
    end else if (m_halt) begin
      m_phase = 0;
    end else if (m_phase == 0 && !m_waitstep) begin
      if (se) m_phase = 1;
    end else if (m_phase == 0) begin
      if (re || (se && !sm)) begin
        m_phase = 1; m_waitstep = 0;
      end else if (pe) begin
        m_waitstep = 0;
      end
    end else begin
      if (pe) m_stopreq = 1;
      if (m_phase == 4 && mw) begin
        m_phase = 4;
      end else if (m_phase == 2 && hlt) begin
        m_halt = 1; m_phase = 0; m_stopreq = 0;
      end else if (m_phase == 5) begin
        m_retire = 1;
        m_count = m_count + 16'd1;
        if (m_stopreq) begin
          m_phase = 0; m_stopreq = 0;
        end else if (sm) begin
          m_phase = 0; m_waitstep = 1;
        end else begin
          m_phase = 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  initial begin
    bit st, sp, sm, sr, mw, r;
    logic [15:0] ins;

    // start, stop, step_mode, step_req, mem_wait, instr -> phase, halted, retire, count
    tbl.push_back('{1, 0, 0, 0, 0, 16'hC000, 3'd1, 0, 0, 16'd0});
    tbl.push_back('{1, 0, 0, 0, 0, 16'hC000, 3'd2, 0, 0, 16'd0});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC000, 3'd3, 0, 0, 16'd0});
    tbl.push_back('{1, 0, 0, 0, 0, 16'hC000, 3'd4, 0, 0, 16'd0});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC000, 3'd5, 0, 0, 16'd0});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC000, 3'd1, 0, 1, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 0, 16'h80F0, 3'd2, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 0, 16'h80F0, 3'd3, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 1, 16'hC000, 3'd4, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 1, 16'hC000, 3'd4, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 1, 16'hC000, 3'd4, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 1, 16'hC000, 3'd4, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC000, 3'd5, 0, 0, 16'd1});
    tbl.push_back('{0, 0, 0, 0, 1, 16'hC000, 3'd1, 0, 1, 16'd2});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC0F0, 3'd2, 0, 0, 16'd2});
    tbl.push_back('{0, 0, 0, 0, 0, 16'hC0F0, 3'd0, 1, 0, 16'd2});
    tbl.push_back('{1, 0, 0, 0, 0, 16'hC0F0, 3'd0, 1, 0, 16'd2});
    tbl.push_back('{0, 1, 0, 1, 0, 16'hC000, 3'd0, 1, 0, 16'd2});
    tbl.push_back('{1, 0, 0, 0, 0, 16'hC000, 3'd0, 1, 0, 16'd2});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].step_mode, tbl[i].step_req, tbl[i].mem_wait,
            tbl[i].instr);
      tick();
      check($sformatf("vec%0d", i), dut_pack(),
            exp_pack(tbl[i].e_phase, tbl[i].e_halted, tbl[i].e_retire, tbl[i].e_count));
    end

    // reset clears halt; single-step sequence
    do_reset();
    bus.step_mode = 1; bus.start = 1; bus.instruction = 16'hC000;
    tick();
    expect_out("step_p1", 1, 0, 0, 0);
    bus.start = 0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      expect_out($sformatf("step_p%0d", k), k, 0, 0, 0);
    end
    tick();
    expect_out("step_end", 0, 0, 1, 1);
    tick();
    expect_out("step_wait", 0, 0, 0, 1);
    bus.start = 1;
    tick();
    expect_out("step_start_ignored", 0, 0, 0, 1);
    bus.start = 0;
    bus.step_req = 1;
    tick();
    expect_out("step_req_p1", 1, 0, 0, 1);
    repeat (9) tick();
    expect_out("step_held_10", 0, 0, 0, 2);
    bus.step_req = 0; bus.step_mode = 0;
    tick();
    bus.start = 1;
    tick();
    expect_out("wait_start_run", 1, 0, 0, 2);
    bus.start = 0;
    repeat (4) tick();
    expect_out("free_p5", 5, 0, 0, 2);
    tick();
    expect_out("free_wrap", 1, 0, 1, 3);
    repeat (4) tick();
    bus.stop = 1;
    tick();
    expect_out("stop_at_last", 0, 0, 1, 4);
    bus.stop = 0;

    // stop during P2 lets the instruction finish
    do_reset();
    bus.start = 1; bus.instruction = 16'hC000;
    tick();
    bus.start = 0;
    tick();
    expect_out("stop_pre", 2, 0, 0, 0);
    bus.stop = 1;
    tick();
    expect_out("stop_p3", 3, 0, 0, 0);
    bus.stop = 0;
    tick();
    tick();
    expect_out("stop_p5", 5, 0, 0, 0);
    tick();
    expect_out("stop_retire", 0, 0, 1, 1);
    tick();
    expect_out("stop_idle", 0, 0, 0, 1);
    bus.step_req = 1;
    tick();
    expect_out("idle_step_ignored", 0, 0, 0, 1);
    bus.step_req = 0; bus.start = 1;
    tick();
    expect_out("idle_restart", 1, 0, 0, 1);
    bus.start = 0;

    // reset mid-instruction with start held high
    tick();
    tick();
    expect_out("pre_rst", 3, 0, 0, 1);
    bus.start = 1; rst = 1;
    tick();
    expect_out("rst_mid", 0, 0, 0, 0);
    rst = 0;
    repeat (3) tick();
    expect_out("rst_no_restart", 0, 0, 0, 0);
    bus.start = 0;
    tick();
    bus.start = 1;
    tick();
    expect_out("rst_fresh_start", 1, 0, 0, 0);
    bus.start = 0;

    // counter wrap on the narrow instance
    do_reset();
    bus3.start = 1;
    tick();
    repeat (40) tick();
    check("wrap_zero", {16'b0, 13'b0, bus3.instr_count}, 32'd0);
    check("wrap_retire", {31'b0, bus3.retire}, 32'd1);
    repeat (5) tick();
    check("wrap_one", {16'b0, 13'b0, bus3.instr_count}, 32'd1);
    bus3.start = 0;

    // randomized run against the reference model
    do_reset();
    model_step(1, 0, 0, 0, 0, 0, 16'h0000);
    st = 0; sp = 0; sm = 0; sr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) st = !st;
      if ($urandom_range(0, 7) == 0) sp = !sp;
      if ($urandom_range(0, 19) == 0) sm = !sm;
      if ($urandom_range(0, 5) == 0) sr = !sr;
      mw = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 249) == 0);
      ins = 16'($urandom);
      if (ins[15:14] == 2'b11 && ins[7:4] == 4'hF && $urandom_range(0, 3) != 0) ins[4] = 1'b0;
      rst = r;
      drive(st, sp, sm, sr, mw, ins);
      model_step(r, st, sp, sm, sr, mw, ins);
      tick();
      check($sformatf("rand%0d", i), dut_pack(),
            exp_pack(3'(m_phase), m_halt, m_retire, m_count));
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
